ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_if.sv | 57 +++++
 rtl/ahb_arbiter.sv | 140 ++++++++++++++
 tb/tb_ahb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// ============================================================================
// ahb_arbiter_if : two-master AHB request/address/data bundle plus muxed bus
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_arbiter_if;
  logic        M0_HBUSREQ;
  logic        M1_HBUSREQ;
  logic [31:0] M0_HADDR;
  logic [31:0] M1_HADDR;
  logic [1:0]  M0_HTRANS;
  logic [1:0]  M1_HTRANS;
  logic [2:0]  M0_HSIZE;
  logic [2:0]  M1_HSIZE;
  logic [2:0]  M0_HBURST;
  logic [2:0]  M1_HBURST;
  logic        M0_HWRITE;
  logic        M1_HWRITE;
  logic [31:0] M0_HWDATA;
  logic [31:0] M1_HWDATA;
  logic        HREADY;

  logic        M0_HGRANT;
  logic        M1_HGRANT;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HMASTER;

  // Arbiter side: takes master requests, drives grants and the shared bus.
  modport master (
    input  M0_HBUSREQ, M1_HBUSREQ,
    input  M0_HADDR, M1_HADDR, M0_HTRANS, M1_HTRANS,
    input  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST,
    input  M0_HWRITE, M1_HWRITE, M0_HWDATA, M1_HWDATA,
    input  HREADY,
    output M0_HGRANT, M1_HGRANT,
    output HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HMASTER
  );

  // Environment side: the masters and the addressed slave.
  modport slave (
    output M0_HBUSREQ, M1_HBUSREQ,
    output M0_HADDR, M1_HADDR, M0_HTRANS, M1_HTRANS,
    output M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST,
    output M0_HWRITE, M1_HWRITE, M0_HWDATA, M1_HWDATA,
    output HREADY,
    input  M0_HGRANT, M1_HGRANT,
    input  HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HMASTER
  );
endinterface

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// ahb_arbiter : two-master AHB arbiter with registered grants and bus mux.
// Optional ARB_ROUND_ROBIN_EN: alternating tie-break plus 7-beat hold limit.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arbiter (
  input  wire logic     clk,
  input  wire logic     rst,
  ahb_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  state_t      tie_winner;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        hmaster;
  logic        dvalid;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hwdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_gnt;
  logic [2:0]  hold_cnt;
  logic        hold_expired;

  assign tie_winner   = last_gnt ? GNT0 : GNT1;
  assign hold_expired = (hold_cnt == 3'd7);
`else
  assign tie_winner   = GNT0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.M0_HBUSREQ && bus.M1_HBUSREQ) next_state = tie_winner;
        else if (bus.M0_HBUSREQ)              next_state = GNT0;
        else if (bus.M1_HBUSREQ)              next_state = GNT1;
        else                                  next_state = IDLE;
      end
      GNT0: begin
        if (!bus.M0_HBUSREQ)                  next_state = bus.M1_HBUSREQ ? GNT1 : IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        else if (bus.M1_HBUSREQ && hold_expired) next_state = GNT1;
`endif
        else                                  next_state = GNT0;
      end
      GNT1: begin
        if (!bus.M1_HBUSREQ)                  next_state = bus.M0_HBUSREQ ? GNT0 : IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        else if (bus.M0_HBUSREQ && hold_expired) next_state = GNT0;
`endif
        else                                  next_state = GNT1;
      end
      default:                                next_state = IDLE;
    endcase
  end

  // Everything advances only on completed beats, so wait states freeze arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      hmaster  <= 1'b0;
      dvalid   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= 1'b1;
      hold_cnt <= 3'd0;
`endif
    end else if (bus.HREADY) begin
      state   <= next_state;
      m0_gnt  <= (next_state == GNT0);
      m1_gnt  <= (next_state == GNT1);
      hmaster <= (state == GNT1);
      dvalid  <= (state != IDLE);
`ifdef ARB_ROUND_ROBIN_EN
      if (next_state == GNT0)      last_gnt <= 1'b0;
      else if (next_state == GNT1) last_gnt <= 1'b1;

      if (next_state != state)                   hold_cnt <= 3'd0;
      else if (state != IDLE && !hold_expired)   hold_cnt <= hold_cnt + 3'd1;
`endif
    end
  end

  always_comb begin
    haddr  = 32'h0;
    htrans = 2'b00;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwrite = 1'b0;
    unique case (state)
      GNT0: begin
        haddr  = bus.M0_HADDR;
        htrans = bus.M0_HTRANS;
        hsize  = bus.M0_HSIZE;
        hburst = bus.M0_HBURST;
        hwrite = bus.M0_HWRITE;
      end
      GNT1: begin
        haddr  = bus.M1_HADDR;
        htrans = bus.M1_HTRANS;
        hsize  = bus.M1_HSIZE;
        hburst = bus.M1_HBURST;
        hwrite = bus.M1_HWRITE;
      end
      default: ;
    endcase
  end

  // Write data belongs to the previous beat's owner, hence the registered select.
  assign hwdata = !dvalid ? 32'h0 : (hmaster ? bus.M1_HWDATA : bus.M0_HWDATA);

  assign bus.M0_HGRANT = m0_gnt;
  assign bus.M1_HGRANT = m1_gnt;
  assign bus.HADDR     = haddr;
  assign bus.HTRANS    = htrans;
  assign bus.HSIZE     = hsize;
  assign bus.HBURST    = hburst;
  assign bus.HWRITE    = hwrite;
  assign bus.HWDATA    = hwdata;
  assign bus.HMASTER   = hmaster;

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
// tb_ahb_arbiter : directed stimulus against a cycle-level arbitration model.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ahb_arbiter_if bus();

  ahb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner -1 = nobody, 0/1 = master index.
  int m_own;
  int m_last;
  int m_hold;
  int m_dvalid;
  int m_downer;

  always @(posedge clk or negedge rst) begin : model
    int nxt;
    int req [2];
    if (!rst) begin
      m_own    = -1;
      m_last   = 1;
      m_hold   = 0;
      m_dvalid = 0;
      m_downer = 0;
    end else if (bus.HREADY === 1'b1) begin
      req[0] = int'(bus.M0_HBUSREQ);
      req[1] = int'(bus.M1_HBUSREQ);
      if (m_own < 0) begin
        if (req[0] != 0 && req[1] != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
          nxt = 1 - m_last;
`else
          nxt = 0;
`endif
        end else if (req[0] != 0) nxt = 0;
        else if (req[1] != 0)     nxt = 1;
        else                      nxt = -1;
      end else if (req[m_own] == 0) begin
        nxt = (req[1 - m_own] != 0) ? 1 - m_own : -1;
      end else begin
        nxt = m_own;
`ifdef ARB_ROUND_ROBIN_EN
        if (m_hold >= 7 && req[1 - m_own] != 0) nxt = 1 - m_own;
`endif
      end
      m_dvalid = (m_own >= 0) ? 1 : 0;
      m_downer = (m_own == 1) ? 1 : 0;
      m_hold   = (nxt == m_own && m_own >= 0) ? m_hold + 1 : 0;
      if (nxt >= 0) m_last = nxt;
      m_own = nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : compare
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_trans;
    logic [2:0]  e_size, e_burst;
    logic        e_write;
    #1;
    e_addr  = (m_own == 0) ? bus.M0_HADDR  : (m_own == 1) ? bus.M1_HADDR  : 32'h0;
    e_trans = (m_own == 0) ? bus.M0_HTRANS : (m_own == 1) ? bus.M1_HTRANS : 2'b00;
    e_size  = (m_own == 0) ? bus.M0_HSIZE  : (m_own == 1) ? bus.M1_HSIZE  : 3'd0;
    e_burst = (m_own == 0) ? bus.M0_HBURST : (m_own == 1) ? bus.M1_HBURST : 3'd0;
    e_write = (m_own == 0) ? bus.M0_HWRITE : (m_own == 1) ? bus.M1_HWRITE : 1'b0;
    e_wdata = (m_dvalid == 0) ? 32'h0 : (m_downer == 1) ? bus.M1_HWDATA : bus.M0_HWDATA;
    chk("mdl_hgrant0", {31'd0, bus.M0_HGRANT}, {31'd0, m_own == 0});
    chk("mdl_hgrant1", {31'd0, bus.M1_HGRANT}, {31'd0, m_own == 1});
    chk("mdl_haddr",   bus.HADDR, e_addr);
    chk("mdl_htrans",  {30'd0, bus.HTRANS}, {30'd0, e_trans});
    chk("mdl_hsize",   {29'd0, bus.HSIZE},  {29'd0, e_size});
    chk("mdl_hburst",  {29'd0, bus.HBURST}, {29'd0, e_burst});
    chk("mdl_hwrite",  {31'd0, bus.HWRITE}, {31'd0, e_write});
    chk("mdl_hwdata",  bus.HWDATA, e_wdata);
    chk("mdl_hmaster", {31'd0, bus.HMASTER}, m_downer[31:0]);
  end

  task automatic idle_inputs();
    bus.M0_HBUSREQ = 1'b0;  bus.M1_HBUSREQ = 1'b0;
    bus.M0_HADDR   = 32'h0; bus.M1_HADDR   = 32'h0;
    bus.M0_HTRANS  = 2'b00; bus.M1_HTRANS  = 2'b00;
    bus.M0_HSIZE   = 3'd2;  bus.M1_HSIZE   = 3'd2;
    bus.M0_HBURST  = 3'd0;  bus.M1_HBURST  = 3'd1;
    bus.M0_HWRITE  = 1'b0;  bus.M1_HWRITE  = 1'b0;
    bus.M0_HWDATA  = 32'h0; bus.M1_HWDATA  = 32'h0;
    bus.HREADY     = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_hgrant0", {31'd0, bus.M0_HGRANT}, 32'd0);
    chk("rst_hgrant1", {31'd0, bus.M1_HGRANT}, 32'd0);
    chk("rst_htrans",  {30'd0, bus.HTRANS},    32'd0);
    chk("rst_hwdata",  bus.HWDATA,             32'd0);
    chk("rst_hmaster", {31'd0, bus.HMASTER},   32'd0);
    rst = 1'b1;

    // Single M1 request: grant after one edge, HMASTER one edge later.
    bus.M1_HBUSREQ = 1'b1;
    bus.M1_HTRANS  = 2'b10;
    bus.M1_HADDR   = 32'h0000_2000;
    bus.M1_HWDATA  = 32'h1111_2222;
    tick();
    chk("m1_grant",      {31'd0, bus.M1_HGRANT}, 32'd1);
    chk("m1_htrans",     {30'd0, bus.HTRANS},    32'd2);
    chk("m1_haddr",      bus.HADDR,              32'h0000_2000);
    chk("m1_hmaster_e1", {31'd0, bus.HMASTER},   32'd0);
    tick();
    chk("m1_hmaster_e2", {31'd0, bus.HMASTER},   32'd1);
    chk("m1_hwdata",     bus.HWDATA,             32'h1111_2222);

    // Both request from reset: M0 wins, then M1 once M0 releases.
    do_reset();
    bus.M0_HBUSREQ = 1'b1;
    bus.M1_HBUSREQ = 1'b1;
    tick();
    chk("tie_reset_g0", {31'd0, bus.M0_HGRANT}, 32'd1);
    @(negedge clk);
    bus.M0_HBUSREQ = 1'b0;
    tick();
    chk("handover_g1", {31'd0, bus.M1_HGRANT}, 32'd1);
    chk("handover_g0", {31'd0, bus.M0_HGRANT}, 32'd0);

    // Tie after M0 was last granted: RR favours M1, fixed priority keeps M0.
    do_reset();
    bus.M0_HBUSREQ = 1'b1;
    tick();
    @(negedge clk);
    bus.M0_HBUSREQ = 1'b0;
    tick();
    chk("idle_again_g0", {31'd0, bus.M0_HGRANT}, 32'd0);
    @(negedge clk);
    bus.M0_HBUSREQ = 1'b1;
    bus.M1_HBUSREQ = 1'b1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_after_m0", {31'd0, bus.M1_HGRANT}, 32'd1);
`else
    chk("tie_after_m0", {31'd0, bus.M0_HGRANT}, 32'd1);
`endif

    // Wait states: write data and owner hold, request glitches ignored.
    do_reset();
    bus.M0_HBUSREQ = 1'b1;
    bus.M0_HADDR   = 32'h0000_0100;
    bus.M0_HTRANS  = 2'b10;
    bus.M0_HWRITE  = 1'b1;
    bus.M0_HWDATA  = 32'hDEAD_BEEF;
    tick();
    chk("ws_haddr", bus.HADDR, 32'h0000_0100);
    tick();
    chk("ws_hwdata_pre", bus.HWDATA, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.HREADY     = 1'b0;
    bus.M0_HBUSREQ = 1'b0;
    bus.M1_HBUSREQ = 1'b1;
    tick();
    chk("ws1_g0",      {31'd0, bus.M0_HGRANT}, 32'd1);
    chk("ws1_hwdata",  bus.HWDATA,             32'hDEAD_BEEF);
    chk("ws1_hmaster", {31'd0, bus.HMASTER},   32'd0);
    @(negedge clk);
    bus.M0_HBUSREQ = 1'b1;
    bus.M1_HBUSREQ = 1'b0;
    tick();
    chk("ws2_g0",     {31'd0, bus.M0_HGRANT}, 32'd1);
    chk("ws2_hwdata", bus.HWDATA,             32'hDEAD_BEEF);
    @(negedge clk);
    bus.HREADY = 1'b1;
    tick();
    chk("ws_end_g0", {31'd0, bus.M0_HGRANT}, 32'd1);

    // Continuous contention: hold limit under RR, indefinite ownership otherwise.
    do_reset();
    bus.M0_HBUSREQ = 1'b1;
    bus.M1_HBUSREQ = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.M0_HGRANT === 1'b1) n++;
      else break;
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("hold_cycles_g0", n, 32'd8);
    chk("hold_switch_g1", {31'd0, bus.M1_HGRANT}, 32'd1);
`else
    chk("hold_cycles_g0", n, 32'd25);
`endif

    // Asynchronous reset while GNT1 is wait-stated.
    do_reset();
    bus.M1_HBUSREQ = 1'b1;
    bus.M1_HTRANS  = 2'b10;
    bus.M1_HWDATA  = 32'h0000_0055;
    tick();
    tick();
    chk("pre_rst_hwdata", bus.HWDATA, 32'h0000_0055);
    @(negedge clk);
    bus.HREADY = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_g0",      {31'd0, bus.M0_HGRANT}, 32'd0);
    chk("arst_g1",      {31'd0, bus.M1_HGRANT}, 32'd0);
    chk("arst_htrans",  {30'd0, bus.HTRANS},    32'd0);
    chk("arst_hwdata",  bus.HWDATA,             32'd0);
    chk("arst_hmaster", {31'd0, bus.HMASTER},   32'd0);
    @(negedge clk);
    bus.M1_HBUSREQ = 1'b0;
    bus.HREADY     = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_g1", {31'd0, bus.M1_HGRANT}, 32'd0);
    @(negedge clk);
    bus.M0_HBUSREQ = 1'b1;
    tick();
    chk("post_rst_g0", {31'd0, bus.M0_HGRANT}, 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
